// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master round-robin arbiter with loader lock for a single-port data RAM
module dram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {IDLE, LOCK1} state_t;

  state_t      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic        pending_valid_q, pending_valid_d;
  logic        pending_owner_q, pending_owner_d;
  logic        pending_oor_q, pending_oor_d;

  logic              lock_active;
  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              in_range;
  logic              unused_addr_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_last_q       <= 1'b1;
      pending_valid_q <= 1'b0;
      pending_owner_q <= 1'b0;
      pending_oor_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      pending_valid_q <= pending_valid_d;
      pending_owner_q <= pending_owner_d;
      pending_oor_q   <= pending_oor_d;
    end
  end

  // The lock only holds while m1_lock stays high; the release cycle arbitrates normally.
  always_comb begin
    lock_active = (state_q == LOCK1) && m1_lock;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (lock_active) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m0_gnt = rr_last_q;
        m1_gnt = !rr_last_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    gnt_any   = m0_gnt || m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    sel_wstrb = m1_gnt ? m1_wstrb : m0_wstrb;
    in_range  = (sel_addr[ADDR_W-1:RAM_AW+2] == '0);
    unused_addr_lsb = ^sel_addr[1:0];

    ram_en    = gnt_any && in_range;
    ram_we    = (ram_en && sel_we) ? sel_wstrb : 4'b0000;
    ram_addr  = sel_addr[RAM_AW+1:2];
    ram_wdata = sel_wdata;

    state_d = (m1_lock && (lock_active || m1_gnt)) ? LOCK1 : IDLE;
    rr_last_d = rr_last_q;
    if (m1_gnt) begin
      rr_last_d = 1'b1;
    end else if (m0_gnt) begin
      rr_last_d = 1'b0;
    end

    pending_valid_d = gnt_any && !sel_we;
    pending_owner_d = m1_gnt;
    pending_oor_d   = !in_range;
  end

  // Out-of-range reads still complete, returning zero data.
  always_comb begin
    m0_rvalid = !rst && pending_valid_q && !pending_owner_q;
    m1_rvalid = !rst && pending_valid_q && pending_owner_q;
    m0_rdata  = (m0_rvalid && !pending_oor_q) ? ram_rdata : '0;
    m1_rdata  = (m1_rvalid && !pending_oor_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - vector table, reset sequence and randomized model check for dram_arbiter
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram_mem [0:4095];
  logic [31:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
    logic        lk;
    logic        g0, g1, en, v0;
    logic [31:0] rd0;
    logic        v1;
    logic [31:0] rd1;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0, input logic [3:0] s0,
                              input logic r1, w1, input logic [31:0] a1, d1, input logic [3:0] s1,
                              input logic lk, g0, g1, en, v0, input logic [31:0] rd0,
                              input logic v1, input logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.lk = lk; v.g0 = g0; v.g1 = g1; v.en = en;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_wstrb = v.s0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_wstrb = v.s1;
    m1_lock = v.lk;
  endtask

  task automatic check_outs(input string tag, input logic g0, g1, en, v0, input logic [31:0] rd0,
                            input logic v1, input logic [31:0] rd1);
    chk({tag, " m0_gnt"}, {31'b0, m0_gnt}, {31'b0, g0});
    chk({tag, " m1_gnt"}, {31'b0, m1_gnt}, {31'b0, g1});
    chk({tag, " ram_en"}, {31'b0, ram_en}, {31'b0, en});
    chk({tag, " m0_rvalid"}, {31'b0, m0_rvalid}, {31'b0, v0});
    chk({tag, " m0_rdata"}, m0_rdata, rd0);
    chk({tag, " m1_rvalid"}, {31'b0, m1_rvalid}, {31'b0, v1});
    chk({tag, " m1_rdata"}, m1_rdata, rd1);
  endtask

  vec_t tv[$];
  vec_t idle;

  // Reference model state for the randomized phase
  bit          mrr, mlocked, pv, po;
  logic [31:0] pdata;
  bit          a0, a1;
  logic        q_we0, q_we1;
  logic [31:0] q_addr0, q_addr1, q_d0, q_d1;
  logic [3:0]  q_s0, q_s1;

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h4000 + 4 * $urandom_range(0, 15);
    return 32'h800 + 4 * $urandom_range(0, 15);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    idle = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0, 0,0);

    tv.push_back(mk(1,1,32'h10,32'hDEADBEEF,4'hF, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h10,0,0, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 1,32'hDEADBEEF, 0,0));
    tv.push_back(mk(1,1,32'h0,32'h11223344,4'hF, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(1,1,32'h0,32'h000000AA,4'h1, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h0,0,0, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 1,32'h112233AA, 0,0));
    tv.push_back(mk(0,0,0,0,0, 1,0,32'h4000,0,0, 0, 0,1,0, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0, 1,0));
    tv.push_back(mk(1,0,32'h10,0,0, 1,0,32'h0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h10,0,0, 1,0,32'h0,0,0, 0, 0,1,1, 1,32'hDEADBEEF, 0,0));
    tv.push_back(mk(1,0,32'h10,0,0, 1,0,32'h0,0,0, 0, 1,0,1, 0,0, 1,32'h112233AA));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 1,32'hDEADBEEF, 0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,0,32'h10,0,0, 1,1,32'h100,32'h55AA55AA,4'hF, 1, 0,1,1, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h10,0,0, 1,1,32'h100,32'h55AA55AA,4'hF, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0,0, 1,1,32'h100,32'h55AA55AA,4'hF, 0, 0,1,1, 1,32'hDEADBEEF, 0,0));
    tv.push_back(mk(1,0,32'h100,0,0, 1,1,32'h100,32'h55AA55AA,4'hF, 1, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h100,0,0, 1,1,32'h100,32'h55AA55AA,4'hF, 1, 0,1,1, 1,32'h55AA55AA, 0,0));
    tv.push_back(mk(1,0,32'h100,0,0, 0,0,0,0,0, 1, 0,0,0, 0,0, 0,0));
    tv.push_back(mk(1,0,32'h100,0,0, 0,0,0,0,0, 0, 1,0,1, 0,0, 0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 1,32'h55AA55AA, 0,0));

    // Reset with both masters requesting: nothing may be granted
    rst = 1'b1;
    drive(mk(1,0,32'h10,0,0, 1,0,32'h0,0,0, 0, 0,0,0, 0,0, 0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0,0,0, 0,0, 0,0);
    chk("reset ram_we", {28'b0, ram_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tv[i].g0, tv[i].g1, tv[i].en, tv[i].v0, tv[i].rd0, tv[i].v1, tv[i].rd1);
      @(posedge clk); #1;
    end

    // Read granted, then reset in the following cycle: its rvalid must be lost
    drive(mk(1,0,32'h10,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0, 0,0));
    @(negedge clk);
    check_outs("rstpend grant", 1,0,1, 0,0, 0,0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(idle);
    @(negedge clk);
    check_outs("rstpend during", 0,0,0, 0,0, 0,0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outs("rstpend after", 0,0,0, 0,0, 0,0);
    @(posedge clk); #1;
    drive(mk(1,0,32'h10,0,0, 1,0,32'h0,0,0, 0, 0,0,0, 0,0, 0,0));
    @(negedge clk);
    check_outs("rstpend conflict", 1,0,1, 0,0, 0,0);
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    check_outs("rstpend return", 0,0,0, 1,32'hDEADBEEF, 0,0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    mrr = 1'b0; mlocked = 1'b0; pv = 1'b0; po = 1'b0; pdata = 32'h0;
    a0 = 1'b0; a1 = 1'b0;
    m1_lock = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit eg0, eg1, wwe, oor, een;
      logic [31:0] wa, wd;
      logic [3:0] ws;
      int idx;
      if (!a0 && $urandom_range(0, 2) != 0) begin
        a0 = 1'b1; q_we0 = $urandom_range(0, 1) == 1; q_addr0 = rand_addr();
        q_d0 = $urandom; q_s0 = 4'($urandom_range(0, 15));
      end
      if (!a1 && $urandom_range(0, 2) != 0) begin
        a1 = 1'b1; q_we1 = $urandom_range(0, 1) == 1; q_addr1 = rand_addr();
        q_d1 = $urandom; q_s1 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) m1_lock = !m1_lock;
      m0_req = a0; m0_we = q_we0; m0_addr = q_addr0; m0_wdata = q_d0; m0_wstrb = q_s0;
      m1_req = a1; m1_we = q_we1; m1_addr = q_addr1; m1_wdata = q_d1; m1_wstrb = q_s1;
      @(negedge clk);

      if (mlocked && m1_lock) begin
        eg0 = 1'b0; eg1 = a1;
      end else if (a0 && a1) begin
        eg0 = mrr; eg1 = !mrr;
      end else begin
        eg0 = a0; eg1 = a1;
      end
      wa  = eg1 ? q_addr1 : q_addr0;
      wd  = eg1 ? q_d1 : q_d0;
      ws  = eg1 ? q_s1 : q_s0;
      wwe = eg1 ? q_we1 : q_we0;
      oor = wa >= 32'h4000;
      idx = int'((wa % 32'h4000) / 4);
      een = (eg0 || eg1) && !oor;

      check_outs($sformatf("rnd%0d", cyc), eg0, eg1, een, pv && !po, (pv && !po) ? pdata : 32'h0,
                 pv && po, (pv && po) ? pdata : 32'h0);
      chk($sformatf("rnd%0d ram_we", cyc), {28'b0, ram_we}, (een && wwe) ? {28'b0, ws} : 32'h0);
      if (een) chk($sformatf("rnd%0d ram_addr", cyc), {20'b0, ram_addr}, idx);
      if (een && wwe) chk($sformatf("rnd%0d ram_wdata", cyc), ram_wdata, wd);

      pv = 1'b0;
      if (eg0 || eg1) begin
        if (wwe) begin
          if (!oor)
            for (int b = 0; b < 4; b++)
              if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
          pv = 1'b1; po = eg1;
          pdata = oor ? 32'h0 : ref_mem[idx];
        end
        mrr = eg1;
      end
      mlocked = m1_lock && (mlocked || eg1);
      if (eg0) a0 = 1'b0;
      if (eg1) a1 = 1'b0;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-requester arbiter and sequencer for the SoC's single-port data RAM, placed between the core's load/store unit and the RAM, with a second port for the program/data loader. Each cycle it grants at most one request, drives the RAM port, and routes the one-cycle-latency read data back to the requester that issued the read. Round-robin arbitration and a loader lock give burst preloading exclusive access.

## Interface

Parameters:
- ADDR_W, 32, byte address width of both requester ports
- DATA_W, 32, data width; fixed at 32 (4 byte strobes)
- RAM_AW, 12, RAM word-address width (depth 2^RAM_AW words)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request (m0 = core LSU, m1 = loader)
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address; bits [1:0] ignored
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write enables
- m1_lock  in  1  loader requests exclusive ownership
- m0_gnt / m1_gnt  out  1  request accepted this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rdata / m1_rdata  out  32  read data
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, registered output, valid one cycle after ram_en with ram_we = 0

## Operation

- Requester holds req, we, addr, wdata and wstrb stable until gnt. A granted access completes: a write at the grant edge, a read with rvalid on the next cycle.
- Arbitration in state IDLE:
  - A single requester is granted.
  - If both request, the master other than rr_last is granted.
  - rr_last updates to the granted master on every grant. Reset value is 1, so m0 wins the first conflict.
- Lock FSM, states IDLE and LOCK1:
  - IDLE -> LOCK1 at any edge where m1_gnt = 1 and m1_lock = 1.
  - In LOCK1, m0_gnt = 0, and m1 is granted whenever m1_req = 1.
  - LOCK1 -> IDLE at the first edge where m1_lock = 0. In that cycle arbitration already follows the IDLE rules.
  - rr_last still updates on m1 grants in LOCK1.
- Address range:
  - In range: addr[ADDR_W-1:RAM_AW+2] = 0. ram_addr = addr[RAM_AW+1:2].
  - Out of range: the access is granted but ram_en stays 0. A write is dropped. A read returns rvalid with rdata = 0.
- RAM drive: when no grant, ram_en = 0 and ram_we = 0. On a write grant, ram_we = wstrb. On a read grant, ram_we = 0.
- Read return:
  - Registered pending_valid, pending_owner and pending_oor record the granted read.
  - Next cycle: rvalid is asserted for the recorded owner only. rdata = ram_rdata, or 0 if out of range. The other master's rdata = 0.
- Back-to-back: a new grant is allowed in the same cycle a previous read's rvalid is returned, giving full throughput of one access per cycle.

## Timing

- gnt and all ram_* outputs are combinational from req, addr, state and rr_last in the same cycle.
- rvalid and rdata are asserted exactly 1 cycle after the read grant.
- Reset values:
  - state = IDLE, rr_last = 1, pending_valid = 0
  - all gnt, rvalid and ram_en = 0; ram_we = 0; all rdata = 0
- Reset asserted with a read pending: the pending rvalid is dropped and never emitted after reset.
- m1_lock = 1 while m1 is not granted has no effect; the lock is entered only at a grant.
- Simultaneous write by one master and read by the other: the master chosen by round-robin proceeds and the other stalls. No write-read forwarding is needed because accesses are serialized.

## Test plan

- Reset, then m0 writes 0xDEADBEEF to 0x10 with wstrb = F; next cycle m0 reads 0x10 -> m0_gnt in both cycles, and m0_rvalid with rdata = 0xDEADBEEF one cycle after the read grant; m1_rvalid stays 0.
- Both masters request reads continuously from reset -> grants m0, m1, m0, m1...; each rvalid arrives on the owning port only, 1 cycle after its grant.
- m1 writes with m1_lock = 1 for 4 cycles while m0 requests -> m0_gnt = 0 for those 4 cycles; m0 is granted in the cycle m1_lock drops.
- Byte strobe: write 0x11223344 to word 0, then write 0x000000AA with wstrb = 0001, then read -> 0x112233AA.
- Read of out-of-range address 0x00004000 (RAM_AW = 12) -> granted, ram_en = 0, rvalid next cycle with rdata = 0.
- rst asserted in the cycle after a read grant -> no rvalid on either port, outputs return to reset values, and the next conflict is won by m0.
